bus_arbiter: RTL



---
 rtl/bus_pkg.sv | 6 +
 rtl/bus_arbiter_if.sv | 22 ++
 rtl/bus_arbiter_decode.sv | 13 +
 rtl/bus_arbiter.sv | 86 ++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the two-master data bus arbiter.
package bus_pkg;
  typedef enum logic [1:0] {REG_DM, REG_TM, REG_UM, REG_ERR} region_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;
  localparam int PER_BIT = 30;
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: master request/response signals plus the registered slave bus.
interface bus_arbiter_if;
  logic        m0_req, m0_wr, m1_req, m1_wr, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] bus_addr, bus_wdata;
  logic        dm_rd, dm_wr, tm_rd, tm_wr, um_rd, um_wr;
  logic [31:0] dm_data, tm_data, um_data;
  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata, m1_req, m1_wr, m1_addr, m1_wdata, m1_lock,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_err, m1_err,
    input  bus_addr, bus_wdata, dm_rd, dm_wr, tm_rd, tm_wr, um_rd, um_wr,
    output dm_data, tm_data, um_data
  );
  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata, m1_req, m1_wr, m1_addr, m1_wdata, m1_lock,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_err, m1_err,
    output bus_addr, bus_wdata, dm_rd, dm_wr, tm_rd, tm_wr, um_rd, um_wr,
    input  dm_data, tm_data, um_data
  );
endinterface

// File: rtl/bus_arbiter_decode.sv
// bus_decode: maps the peripheral-select bit and low address byte to a target region.
module bus_decode
  import bus_pkg::*;
#(
  parameter logic [7:0] TM_LIMIT = 8'h15,
  parameter logic [7:0] UM_LIMIT = 8'h20
) (
  input  logic       i_per,
  input  logic [7:0] i_lo,
  output region_t    o_region
);
  assign o_region = !i_per ? REG_DM : i_lo < TM_LIMIT ? REG_TM : i_lo < UM_LIMIT ? REG_UM : REG_ERR;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: fixed-priority two-master arbiter with starvation bound and m1 lock,
// two-stage pipeline (address phase, data phase) onto the DM/TM/UM slaves.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter logic [7:0] TM_LIMIT   = 8'h15,
  parameter logic [7:0] UM_LIMIT   = 8'h20,
  parameter int         STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);
  logic        w_m1_win, w_m0_gnt, w_m1_gnt, w_gnt, w_wr;
  logic [31:0] w_addr, w_wdata, w_slave_data;
  logic [5:0]  w_strb;
  region_t     w_region;
  logic [2:0]  r_starve_cnt;
  logic        r_lock_own, r_wr, r_err_flag, r_err;
  logic [1:0]  r_rvalid;
  logic [31:0] r_bus_addr, r_bus_wdata, r_rdata;
  logic [5:0]  r_strb;
  region_t     r_region;
  owner_t      r_owner;
  assign w_m1_win = bus.m1_req & (r_lock_own | (r_starve_cnt == 3'(STARVE_MAX)) | ~bus.m0_req);
  assign w_m1_gnt = w_m1_win;
  assign w_m0_gnt = bus.m0_req & ~w_m1_win;
  assign w_gnt    = w_m0_gnt | w_m1_gnt;
  assign w_addr   = w_m1_gnt ? bus.m1_addr : bus.m0_addr;
  assign w_wdata  = w_m1_gnt ? bus.m1_wdata : bus.m0_wdata;
  assign w_wr     = w_m1_gnt ? bus.m1_wr : bus.m0_wr;
  bus_decode #(.TM_LIMIT(TM_LIMIT), .UM_LIMIT(UM_LIMIT)) u_decode (
    .i_per    (w_addr[PER_BIT]),
    .i_lo     (w_addr[7:0]),
    .o_region (w_region)
  );
  // strobe order: {dm_rd, dm_wr, tm_rd, tm_wr, um_rd, um_wr}; ERR selects none
  assign w_strb = {6{w_gnt}} & {
    w_region == REG_DM & ~w_wr, w_region == REG_DM & w_wr,
    w_region == REG_TM & ~w_wr, w_region == REG_TM & w_wr,
    w_region == REG_UM & ~w_wr, w_region == REG_UM & w_wr};
  assign w_slave_data = r_region == REG_DM ? bus.dm_data :
                        r_region == REG_TM ? bus.tm_data :
                        r_region == REG_UM ? bus.um_data : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_lock_own   <= 1'b0;
      r_starve_cnt <= '0;
      r_strb       <= '0;
      r_owner      <= OWN_NONE;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_region     <= REG_DM;
      r_wr         <= 1'b0;
      r_err_flag   <= 1'b0;
      r_rvalid     <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_lock_own   <= w_m1_gnt & bus.m1_lock;
      r_starve_cnt <= (!bus.m1_req || w_m1_gnt) ? '0 : r_starve_cnt + 3'(r_starve_cnt != 3'd7);
      r_strb       <= w_strb;
      r_owner      <= w_m1_gnt ? OWN_M1 : w_m0_gnt ? OWN_M0 : OWN_NONE;
      if (w_gnt) begin
        r_bus_addr  <= w_addr;
        r_bus_wdata <= w_wdata;
        r_region    <= w_region;
        r_wr        <= w_wr;
        r_err_flag  <= w_region == REG_ERR;
      end
      r_rvalid <= {r_owner == OWN_M1, r_owner == OWN_M0};
      r_rdata  <= (r_owner == OWN_NONE || r_wr) ? '0 : w_slave_data;
      r_err    <= r_owner != OWN_NONE && r_err_flag;
    end
  assign bus.m0_gnt    = w_m0_gnt;
  assign bus.m1_gnt    = w_m1_gnt;
  assign bus.m0_rvalid = r_rvalid[0];
  assign bus.m1_rvalid = r_rvalid[1];
  assign bus.m0_rdata  = r_rdata;
  assign bus.m1_rdata  = r_rdata;
  assign bus.m0_err    = r_err;
  assign bus.m1_err    = r_err;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;
  assign {bus.dm_rd, bus.dm_wr, bus.tm_rd, bus.tm_wr, bus.um_rd, bus.um_wr} = r_strb;
endmodule
